// File: rtl/uart_rx_reader_if.sv
// Serial receive bundle: rx line towards the receiver, received byte and status pulses back.
interface uart_rx_reader_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (input rx, output data, valid, frame_err, parity_err, busy);
    modport slave  (output rx, input data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_reader.sv
// UART receiver: 2-flop rx synchroniser, mid-bit sampling, 8N1 framing check.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_reader #(
    parameter int unsigned boadrate = 115200,
    parameter int unsigned clk_freq = 50_000_000
) (
    input logic              clk,
    input logic              rst,
    uart_rx_reader_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = clk_freq / boadrate;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);

    localparam logic [2:0] S_HUNT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif
    localparam logic [2:0] S_STOP   = 3'd5;

    logic             r_rx_meta, r_rx_s;
    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_busy, w_busy_nxt;
`ifdef UART_RX_PARITY_EN
    logic             r_par, w_par_nxt;
    logic             r_parity_err, w_parity_err_nxt;
`endif

    // Metastability guard; idle-high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_busy       <= w_busy_nxt;
`ifdef UART_RX_PARITY_EN
            r_par        <= w_par_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + CNT_W'(1);
        w_idx_nxt        = r_idx;
        w_shift_nxt      = r_shift;
        w_data_nxt       = r_data;
        w_valid_nxt      = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_busy_nxt       = r_busy;
`ifdef UART_RX_PARITY_EN
        w_par_nxt        = r_par;
        w_parity_err_nxt = 1'b0;
`endif
        case (r_state)
            // Need a full bit time of idle line before trusting a falling edge
            S_HUNT: begin
                w_busy_nxt = 1'b0;
                if (!r_rx_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_BIT_END) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF_END) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = r_rx_s;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_rx_s;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            // Framing error outranks parity error; either way data is left untouched
            S_STOP: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b0;
                    if (!r_rx_s) begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_HUNT;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par != ^r_shift) begin
                        w_parity_err_nxt = 1'b1;
                        w_state_nxt      = S_IDLE;
`endif
                    end else begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
